// File: rtl/tstate_generator.sv
// tstate_generator
// Registered one-hot T-state ring counter feeding the controller/sequencer.
// Wraps at an instruction-length-dependent last state, supports a sticky
// halt released by resume, counts completed instructions (saturating) and
// flags a corrupted (zero or multi-hot) ring.
// Optional feature macro: TSTATE_STEP_EN adds single-step ports step_mode/step.

module tstate_generator #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_ring_counter,
    input  logic [1:0]       mode,
    input  logic             resume,
`ifdef TSTATE_STEP_EN
    input  logic             step_mode,
    input  logic             step,
`endif
    output logic [14:0]      ring_counter,
    output logic             halted,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic             onehot_err
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } haltState_t;

    // Masks of ring positions at or beyond the last state of each length class;
    // any set bit under the mask means the next advance wraps to T0.
    localparam logic [14:0] LAST_MASK_1B = 15'h7FE0;  // T5 and above
    localparam logic [14:0] LAST_MASK_2B = 15'h7E00;  // T9 and above
    localparam logic [14:0] LAST_MASK_3B = 15'h6000;  // T13 and above
    localparam logic [14:0] RING_T0      = 15'h0001;

    haltState_t       r_state;
    logic [14:0]      r_ring;
    logic             r_instrDone;
    logic [CNT_W-1:0] r_instrCount;
    logic             r_onehotErr;

    haltState_t       w_nextState;
    logic [14:0]      w_nextRing;
    logic             w_nextDone;
    logic [CNT_W-1:0] w_nextCount;
    logic             w_nextErr;
    logic             w_advance;
    logic [14:0]      w_lastMask;
    logic             w_isOneHot;
    logic             w_wrap;
    logic [14:0]      w_ringAdv;
    logic             w_stepBlock;

`ifdef TSTATE_STEP_EN
    logic r_stepPrev;
    logic r_stepEdge;

    // Registered rising-edge detector on step; the edge enables one advance on the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stepPrev <= 1'b0;
            r_stepEdge <= 1'b0;
        end else begin
            r_stepPrev <= step;
            r_stepEdge <= step & ~r_stepPrev;
        end
    end

    assign w_stepBlock = step_mode & ~r_stepEdge;
`else
    assign w_stepBlock = 1'b0;
`endif

    // Decode the wrap point from the instruction length and precompute the advanced ring.
    always_comb begin
        w_lastMask = LAST_MASK_1B;
        case (mode)
            2'b01:   w_lastMask = LAST_MASK_2B;
            2'b10:   w_lastMask = LAST_MASK_3B;
            default: w_lastMask = LAST_MASK_1B;
        endcase
        w_isOneHot = (r_ring != 15'd0) && ((r_ring & (r_ring - 15'd1)) == 15'd0);
        w_wrap     = |(r_ring & w_lastMask);
        w_ringAdv  = w_wrap ? RING_T0 : {r_ring[13:0], 1'b0};
    end

    // Next-state and next-datapath decision: error recovery, then halt/resume, then halt request, then step gating.
    always_comb begin
        w_nextState = r_state;
        w_nextRing  = r_ring;
        w_nextDone  = 1'b0;
        w_nextCount = r_instrCount;
        w_nextErr   = r_onehotErr;
        w_advance   = 1'b0;

        if (!w_isOneHot) begin
            w_nextRing = RING_T0;
            w_nextErr  = 1'b1;
        end else if (r_state == ST_HALT) begin
            if (resume) begin
                w_advance   = 1'b1;
                w_nextState = ST_RUN;
            end
        end else if (!enable_ring_counter) begin
            w_nextState = ST_HALT;
        end else if (!w_stepBlock) begin
            w_advance = 1'b1;
        end

        if (w_advance) begin
            w_nextRing = w_ringAdv;
            w_nextDone = w_wrap;
            if (w_wrap && !(&r_instrCount)) begin
                w_nextCount = r_instrCount + CNT_W'(1);
            end
        end
    end

    // Halt state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Ring, completion pulse, instruction counter and sticky error registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ring       <= RING_T0;
            r_instrDone  <= 1'b0;
            r_instrCount <= '0;
            r_onehotErr  <= 1'b0;
        end else begin
            r_ring       <= w_nextRing;
            r_instrDone  <= w_nextDone;
            r_instrCount <= w_nextCount;
            r_onehotErr  <= w_nextErr;
        end
    end

    assign ring_counter = r_ring;
    assign halted       = (r_state == ST_HALT);
    assign instr_done   = r_instrDone;
    assign instr_count  = r_instrCount;
    assign onehot_err   = r_onehotErr;

endmodule

// File: tb/tb_tstate_generator.sv
// Testbench for tstate_generator: stimulus process drives inputs on the falling
// edge and pushes the reference model's expected outputs into a queue; a
// monitor pops and compares after every rising edge. The counter is built
// narrow so that saturation is reachable quickly.

module tb_tstate_generator;

    localparam int CW        = 4;
    localparam int COUNT_MAX = (1 << CW) - 1;

    typedef struct {
        logic [14:0]   ring;
        logic          halted;
        logic          done;
        logic [CW-1:0] count;
        logic          err;
    } expected_t;

    logic          clk;
    logic          rst_n;
    logic          enable_ring_counter;
    logic [1:0]    mode;
    logic          resume;
`ifdef TSTATE_STEP_EN
    logic          step_mode;
    logic          step;
`endif
    logic [14:0]   ring_counter;
    logic          halted;
    logic          instr_done;
    logic [CW-1:0] instr_count;
    logic          onehot_err;

    expected_t expQ[$];
    int checks   = 0;
    int failures = 0;

    // Reference model state: T-state as a plain index.
    int mIdx   = 0;
    bit mHalt  = 0;
    bit mDone  = 0;
    int mCount = 0;
    bit mErr   = 0;

    tstate_generator #(.CNT_W(CW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable_ring_counter (enable_ring_counter),
        .mode                (mode),
        .resume              (resume),
`ifdef TSTATE_STEP_EN
        .step_mode           (step_mode),
        .step                (step),
`endif
        .ring_counter        (ring_counter),
        .halted              (halted),
        .instr_done          (instr_done),
        .instr_count         (instr_count),
        .onehot_err          (onehot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lastOf(input logic [1:0] md);
        case (md)
            2'b01:   return 9;
            2'b10:   return 13;
            default: return 5;
        endcase
    endfunction

    // One edge of the reference model, from the rules for reset, error, halt and advance.
    task automatic modelStep(input bit rstn, input bit en, input logic [1:0] md,
                             input bit res, input bit corrupt);
        bit adv;
        adv   = 0;
        mDone = 0;
        if (!rstn) begin
            mIdx = 0; mHalt = 0; mCount = 0; mErr = 0;
        end else if (corrupt) begin
            mIdx = 0; mErr = 1;
        end else if (mHalt) begin
            if (res) begin adv = 1; mHalt = 0; end
        end else if (!en) begin
            mHalt = 1;
        end else begin
            adv = 1;
        end
        if (adv) begin
            if (mIdx >= lastOf(md)) begin
                mIdx  = 0;
                mDone = 1;
                if (mCount < COUNT_MAX) mCount++;
            end else begin
                mIdx++;
            end
        end
    endtask

    // Drive one cycle of inputs (optionally corrupting the ring) and queue the expected response.
    task automatic applyStimulus(input bit rstn, input bit en, input logic [1:0] md,
                                 input bit res, input int corruptKind);
        expected_t e;
        @(negedge clk);
        rst_n               = rstn;
        enable_ring_counter = en;
        mode                = md;
        resume              = res;
        if (corruptKind == 1) begin
            force dut.r_ring = 15'h0000;
            release dut.r_ring;
        end else if (corruptKind == 2) begin
            force dut.r_ring = 15'h0011;
            release dut.r_ring;
        end
        modelStep(rstn, en, md, res, corruptKind != 0);
        e.ring   = 15'(1) << mIdx;
        e.halted = mHalt;
        e.done   = mDone;
        e.count  = CW'(mCount);
        e.err    = mErr;
        expQ.push_back(e);
    endtask

    task automatic checkOne(input string name, input logic [14:0] act, input logic [14:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    task automatic checkOutput(input expected_t e);
        checkOne("ring_counter", ring_counter, e.ring);
        checkOne("halted", 15'(halted), 15'(e.halted));
        checkOne("instr_done", 15'(instr_done), 15'(e.done));
        checkOne("instr_count", 15'(instr_count), 15'(e.count));
        checkOne("onehot_err", 15'(onehot_err), 15'(e.err));
    endtask

    // Monitor: every rising edge produces a new registered output set to compare.
    initial begin
        expected_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        rst_n               = 1'b0;
        enable_ring_counter = 1'b1;
        mode                = 2'b00;
        resume              = 1'b0;
`ifdef TSTATE_STEP_EN
        step_mode           = 1'b0;
        step                = 1'b0;
`endif

        // Reset.
        repeat (2) applyStimulus(0, 1, 2'b00, 0, 0);

        // 1-byte instructions: two full passes.
        repeat (12) applyStimulus(1, 1, 2'b00, 0, 0);

        // 3-byte instruction: full walk T0..T13, T0.
        repeat (14) applyStimulus(1, 1, 2'b10, 0, 0);

        // Halt at T4, hold 20 cycles with random enable, then resume.
        for (int i = 0; i < 20 && mIdx != 4; i++) applyStimulus(1, 1, 2'b00, 0, 0);
        applyStimulus(1, 0, 2'b00, 0, 0);
        repeat (20) applyStimulus(1, 1'($urandom_range(0, 1)), 2'b00, 0, 0);
        applyStimulus(1, 0, 2'b00, 1, 0);
        applyStimulus(1, 1, 2'b00, 0, 0);

        // Mode drop from 2-byte to 1-byte at T8.
        for (int i = 0; i < 20 && mIdx != 8; i++) applyStimulus(1, 1, 2'b01, 0, 0);
        applyStimulus(1, 1, 2'b00, 0, 0);
        repeat (3) applyStimulus(1, 1, 2'b11, 0, 0);

        // Counter saturation.
        repeat (110) applyStimulus(1, 1, 2'b00, 0, 0);

        // Corrupted ring: all-zero, then multi-hot, then error stays until reset.
        applyStimulus(1, 1, 2'b00, 0, 1);
        repeat (3) applyStimulus(1, 1, 2'b00, 0, 0);
        applyStimulus(1, 1, 2'b00, 0, 2);
        repeat (3) applyStimulus(1, 1, 2'b10, 0, 0);
        applyStimulus(1, 0, 2'b00, 0, 0);
        applyStimulus(1, 0, 2'b00, 0, 2);
        applyStimulus(1, 1, 2'b00, 1, 0);
        applyStimulus(0, 1, 2'b00, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [1:0] md;
            md = 2'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 63) != 0),
                          ($urandom_range(0, 7) != 0),
                          ($urandom_range(0, 2) == 0) ? md : mode,
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 99) == 0) ? int'($urandom_range(1, 2)) : 0);
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: actual=%0d required=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tstate_generator.md
# tstate_generator

Registered one-hot T-state (ring counter) generator that sits directly upstream of the controller/sequencer. Drives its 15-bit `ring_counter` input and closes the loop on its `enable_ring_counter` and `mode` outputs. Provides:
- instruction-length-dependent wrap;
- a sticky halt with resume;
- a completed-instruction counter;
- one-hot integrity checking.

## Interface
Parameters:
- `CNT_W`, 16, width of the completed-instruction counter.

Ports:
- `clk`  input  1  single system clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `enable_ring_counter`  input  1  advance request from the sequencer; 0 = halt request.
- `mode`  input  2  instruction length class from the sequencer: 00 = 1-byte, 01 = 2-byte, 10 = 3-byte, 11 = reserved.
- `resume`  input  1  level; releases a halt.
- `ring_counter`  output  15  one-hot T-state; bit k = Tk.
- `halted`  output  1  high while the generator is frozen by a halt.
- `instr_done`  output  1  one-cycle pulse, high in the cycle the ring returns to T0 by normal wrap.
- `instr_count`  output  CNT_W  saturating count of completed instructions.
- `onehot_err`  output  1  sticky flag; set when `ring_counter` is found not one-hot.
- `step_mode`, `step`  input  1 each  only present with `TSTATE_STEP_EN`; see Configuration.

## Operation
- Last state L by mode:
  - 00 → T5
  - 01 → T9
  - 10 → T13
  - 11 → T5
- Advance: Tk → Tk+1 for k < L; TL → T0.
- Mode drops mid-instruction: if the current index is greater than L, the next advance goes to T0. This counts as a normal wrap.
- T14 is never reached in normal operation.
- Advance condition, in priority order:
  1. `rst_n` = 0: reset all state.
  2. Illegal ring (zero or multi-hot): force T0 and set `onehot_err`. Does not pulse `instr_done` or count.
  3. `halted` = 1: if `resume` = 1, advance one state and clear `halted`; otherwise hold.
  4. `enable_ring_counter` = 0: hold the ring and set `halted`.
  5. Otherwise advance.
- Halt state machine:
  - RUN → HALT when `enable_ring_counter` is sampled 0 while not halted.
  - HALT → RUN when `resume` is sampled 1.
  - While in HALT, `enable_ring_counter` is ignored. This avoids deadlock, because the sequencer holds it low while the ring sits at the HLT state.
- Wrap (TL → T0, including the mode-drop wrap) sets `instr_done` = 1 for exactly the next cycle.
- Wrap increments `instr_count` by 1, saturating at all-ones.
- A resume that wraps counts as a normal wrap.

## Timing
- Reset values:
  - `ring_counter` = 15'b000000000000001 (T0)
  - `halted` = 0
  - `instr_done` = 0
  - `instr_count` = 0
  - `onehot_err` = 0
- All outputs are registered. No combinational path from any input to any output.
- One edge per advance. `ring_counter` changes one cycle after the sampled condition.
- `mode` and `enable_ring_counter` are sampled on the same edge that updates the ring, i.e. they are the sequencer's decode of the current state.
- Halt latency:
  - Sampling `enable_ring_counter` = 0 at state Tk holds the ring at Tk and raises `halted` on the same edge.
  - The ring remains at Tk until resume.
- Resume latency: `resume` sampled high → ring is Tk+1 (or T0) and `halted` is 0 after that edge.
- Reset mid-instruction or mid-halt returns everything to reset values at the next edge.
- `onehot_err` is cleared only by reset.

## Configuration
- Macro: `TSTATE_STEP_EN`.
- Defined:
  - Adds the `step_mode` and `step` ports and an internal registered rising-edge detector on `step`.
  - While `step_mode` = 1 and not halted, the ring advances only in cycles where a 0→1 transition of `step` was detected on the previous edge. Otherwise it holds, without setting `halted`.
  - Halt, resume, reset and error recovery keep their priority above stepping.
  - With `step_mode` = 0, behaviour is identical to the undefined case.
- Undefined: no step ports; the ring advances every cycle that the rules above allow.

## Test plan
- Reset, then `mode` = 00 with enable high for 12 cycles → ring T0..T5, T0..T5. `instr_done` pulses at cycles 6 and 12. `instr_count` = 2.
- `mode` = 10 → ring walks T0..T13 then T0. A single `instr_done` pulse. T14 never asserted.
- At T4, drive enable = 0 → `halted` = 1 and ring holds T4 for 20 cycles regardless of enable. Pulse `resume` for 1 cycle → T5 then T0, `halted` = 0, count +1.
- At T8 with `mode` = 01, switch `mode` to 00 → next ring T0, `instr_done` = 1.
- Force `instr_count` to 0xFFFF, complete one instruction → stays 0xFFFF. Force ring to 0 or to 0x0011 → next edge T0, `onehot_err` = 1 until `rst_n` = 0.
- With `TSTATE_STEP_EN` and `step_mode` = 1: hold `step` low for 10 cycles → ring stays T0. Three 0→1 `step` edges → ring T3.
